// File: rtl/bullet_fire_ctrl.sv
// Per-tank fire controller: edge-detects the fire key, enforces a cooldown,
// picks the lowest free bullet slot and computes the muzzle spawn point.
module bullet_fire_ctrl #(
  parameter int unsigned NUM_BULLETS     = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned MUZZLE_OFFSET   = 16,
  parameter int unsigned BULLET_STEP     = 4,
  parameter int unsigned BULLET_LIFE     = 3,
  localparam int unsigned POS_W          = 32,
  localparam int unsigned DIR_W          = 2,
  localparam int unsigned BYTE_W         = 8
) (
  input  logic                   frameClk,
  input  logic                   reset,
  input  logic                   fireBtn,
  input  logic [POS_W-1:0]       tankPosX,
  input  logic [POS_W-1:0]       tankPosY,
  input  logic [DIR_W-1:0]       tankDir,
  input  logic [NUM_BULLETS-1:0] bulletExists,
  output logic [NUM_BULLETS-1:0] sigSpawn,
  output logic [POS_W-1:0]       bulletStartX,
  output logic [POS_W-1:0]       bulletStartY,
  output logic [DIR_W-1:0]       bulletStartDir,
  output logic [BYTE_W-1:0]      bulletStep,
  output logic [BYTE_W-1:0]      bulletLife,
  output logic                   fireReady,
  output logic [BYTE_W-1:0]      shotCount
);

  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

  localparam int unsigned CNT_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [POS_W-1:0] OFFSET = POS_W'(MUZZLE_OFFSET);

  typedef enum logic {IDLE, COOLDOWN} fireState_t;

  fireState_t             state, stateNext;
  logic [CNT_W-1:0]       cnt, cntNext;
  logic                   fireBtnPrev;
  logic                   fireEdge, anyFree, dirValid, fireGo;
  logic [NUM_BULLETS-1:0] freeMask;
  logic [POS_W-1:0]       muzzleX, muzzleY;
  logic [NUM_BULLETS-1:0] spawnNext;
  logic [POS_W-1:0]       startXNext, startYNext;
  logic [DIR_W-1:0]       startDirNext;
  logic [BYTE_W-1:0]      shotCountNext;

  assign fireEdge   = fireBtn & ~fireBtnPrev;
  assign anyFree    = |(~bulletExists);
  // Isolates the lowest zero bit of bulletExists as a one-hot slot select.
  assign freeMask   = ~bulletExists & (bulletExists + NUM_BULLETS'(1));
  assign fireGo     = (state == IDLE) && fireEdge && anyFree && dirValid;
  assign fireReady  = (state == IDLE) && anyFree;
  assign bulletStep = BYTE_W'(BULLET_STEP);
  assign bulletLife = BYTE_W'(BULLET_LIFE);

  // Muzzle point: subtracting directions clamp at 0, adding directions wrap.
  always_comb begin
    muzzleX  = tankPosX;
    muzzleY  = tankPosY;
    dirValid = 1'b1;
    case (tankDir)
      DIR_UP:    muzzleY = (tankPosY >= OFFSET) ? tankPosY - OFFSET : '0;
      DIR_DOWN:  muzzleY = tankPosY + OFFSET;
      DIR_LEFT:  muzzleX = (tankPosX >= OFFSET) ? tankPosX - OFFSET : '0;
      DIR_RIGHT: muzzleX = tankPosX + OFFSET;
      default:   dirValid = 1'b0;
    endcase
  end

  always_ff @(posedge frameClk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      fireBtnPrev    <= 1'b1;
      sigSpawn       <= '0;
      bulletStartX   <= '0;
      bulletStartY   <= '0;
      bulletStartDir <= DIR_RIGHT;
      shotCount      <= '0;
    end else begin
      state          <= stateNext;
      cnt            <= cntNext;
      fireBtnPrev    <= fireBtn;
      sigSpawn       <= spawnNext;
      bulletStartX   <= startXNext;
      bulletStartY   <= startYNext;
      bulletStartDir <= startDirNext;
      shotCount      <= shotCountNext;
      if (state == IDLE && fireEdge && !dirValid)
        $error("bullet_fire_ctrl: fire with invalid tankDir %0d ignored", tankDir);
    end
  end

  // Next-state: a shot arms the cooldown, which counts down to zero.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (fireGo) begin
          stateNext = COOLDOWN;
          cntNext   = CNT_W'(COOLDOWN_FRAMES - 1);
        end
      end
      COOLDOWN: begin
        if (cnt == '0) stateNext = IDLE;
        else           cntNext   = cnt - CNT_W'(1);
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs: spawn pulse and start parameters are loaded only on a shot.
  always_comb begin
    spawnNext     = '0;
    startXNext    = bulletStartX;
    startYNext    = bulletStartY;
    startDirNext  = bulletStartDir;
    shotCountNext = shotCount;
    if (fireGo) begin
      spawnNext     = freeMask;
      startXNext    = muzzleX;
      startYNext    = muzzleY;
      startDirNext  = tankDir;
      shotCountNext = shotCount + BYTE_W'(1);
    end
  end

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Bench for bullet_fire_ctrl: directed scenarios then random stimulus,
// all checked against a cycle-distance reference model.
module tb_bullet_fire_ctrl;

  localparam int NB = 4;
  localparam int CD = 8;
  localparam longint OFFL = 16;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  logic          frameClk = 1'b0;
  logic          reset = 1'b1;
  logic          fireBtn = 1'b0;
  logic [31:0]   tankPosX = 32'd100, tankPosY = 32'd200;
  logic [1:0]    tankDir = RIGHT;
  logic [NB-1:0] bulletExists = '0;
  logic [NB-1:0] sigSpawn;
  logic [31:0]   bulletStartX, bulletStartY;
  logic [1:0]    bulletStartDir;
  logic [7:0]    bulletStep, bulletLife, shotCount;
  logic          fireReady;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          cyc;
  int          lastFire;
  bit          prevBtn;
  logic [NB-1:0] expSpawn;
  logic [31:0] expX, expY;
  logic [1:0]  expDir;
  logic [7:0]  expShots;

  bullet_fire_ctrl dut (
    .frameClk(frameClk), .reset(reset), .fireBtn(fireBtn),
    .tankPosX(tankPosX), .tankPosY(tankPosY), .tankDir(tankDir),
    .bulletExists(bulletExists), .sigSpawn(sigSpawn),
    .bulletStartX(bulletStartX), .bulletStartY(bulletStartY),
    .bulletStartDir(bulletStartDir), .bulletStep(bulletStep),
    .bulletLife(bulletLife), .fireReady(fireReady), .shotCount(shotCount)
  );

  always #5 frameClk = ~frameClk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Spawn point from plain signed arithmetic: clamp below zero, wrap above 2^32.
  task automatic muzzle(input logic [1:0] d, input longint x, input longint y,
                        output logic [31:0] ox, output logic [31:0] oy);
    longint nx, ny;
    nx = x;
    ny = y;
    case (d)
      UP:      ny = y - OFFL;
      DOWN:    ny = y + OFFL;
      LEFT:    nx = x - OFFL;
      default: nx = x + OFFL;
    endcase
    if (nx < 0) nx = 0;
    if (ny < 0) ny = 0;
    ox = 32'(nx & 64'hFFFF_FFFF);
    oy = 32'(ny & 64'hFFFF_FFFF);
  endtask

  // One frame: predict from this cycle's inputs, clock, compare.
  task automatic tick();
    bit edgeNow, idle, anyFree;
    int slot;
    logic [NB-1:0] one;
    #1;
    idle    = (cyc - lastFire) >= (CD + 1);
    anyFree = (bulletExists != '1);
    checkVal("fireReady", 32'(fireReady), 32'(idle && anyFree));
    edgeNow = fireBtn && !prevBtn;
    expSpawn = '0;
    if (reset) begin
      expX = 0; expY = 0; expDir = RIGHT; expShots = 0;
      prevBtn = 1'b1;
      lastFire = -1000;
    end else begin
      prevBtn = fireBtn;
      if (edgeNow && idle && anyFree) begin
        slot = 0;
        for (int i = NB - 1; i >= 0; i--) if (!bulletExists[i]) slot = i;
        one = 1;
        expSpawn = one << slot;
        muzzle(tankDir, longint'(tankPosX), longint'(tankPosY), expX, expY);
        expDir = tankDir;
        expShots = 8'((int'(expShots) + 1) % 256);
        lastFire = cyc;
      end
    end
    @(posedge frameClk);
    #1;
    cyc++;
    checkVal("sigSpawn", 32'(sigSpawn), 32'(expSpawn));
    checkVal("startX", bulletStartX, expX);
    checkVal("startY", bulletStartY, expY);
    checkVal("startDir", 32'(bulletStartDir), 32'(expDir));
    checkVal("shotCount", 32'(shotCount), 32'(expShots));
  endtask

  initial begin
    repeat (2) @(posedge frameClk);
    #1;
    cyc = 0; lastFire = -1000; prevBtn = 1'b1;
    expSpawn = '0; expX = 0; expY = 0; expDir = RIGHT; expShots = 0;
    tick();
    checkVal("rst_step", 32'(bulletStep), 32'd4);
    checkVal("rst_life", 32'(bulletLife), 32'd3);
    reset = 1'b0;
    tick();

    // First shot from (100,200) facing right
    fireBtn = 1'b1;
    tick();
    checkVal("t1_spawn", 32'(sigSpawn), 32'd1);
    checkVal("t1_x", bulletStartX, 32'd116);
    checkVal("t1_y", bulletStartY, 32'd200);
    tick();
    checkVal("t1_pulse", 32'(sigSpawn), 32'd0);

    // Held button fires only once
    repeat (40) tick();
    checkVal("t2_shots", 32'(shotCount), 32'd1);

    // Lowest free slot, then all slots busy
    fireBtn = 1'b0; bulletExists = 4'b0101;
    tick();
    fireBtn = 1'b1;
    tick();
    checkVal("t3_spawn", 32'(sigSpawn), 32'd2);
    fireBtn = 1'b0;
    repeat (10) tick();
    bulletExists = 4'hF; fireBtn = 1'b1;
    tick();
    checkVal("t3_full", 32'(sigSpawn), 32'd0);
    checkVal("t3_ready", 32'(fireReady), 32'd0);

    // Edge at t=5 dropped by cooldown, edge at t=9 accepted
    fireBtn = 1'b0; bulletExists = '0;
    repeat (3) tick();
    fireBtn = 1'b1;
    tick();
    checkVal("t4_first", 32'(sigSpawn), 32'd1);
    fireBtn = 1'b0;
    repeat (4) tick();
    fireBtn = 1'b1;
    tick();
    checkVal("t4_drop", 32'(sigSpawn), 32'd0);
    fireBtn = 1'b0;
    repeat (3) tick();
    fireBtn = 1'b1;
    tick();
    checkVal("t4_second", 32'(sigSpawn), 32'd1);

    // Saturating muzzle for UP and LEFT
    fireBtn = 1'b0;
    repeat (10) tick();
    tankDir = UP; tankPosX = 32'd50; tankPosY = 32'd10; fireBtn = 1'b1;
    tick();
    checkVal("t5_upY", bulletStartY, 32'd0);
    checkVal("t5_upX", bulletStartX, 32'd50);
    fireBtn = 1'b0;
    repeat (10) tick();
    tankDir = LEFT; tankPosX = 32'd3; fireBtn = 1'b1;
    tick();
    checkVal("t5_leftX", bulletStartX, 32'd0);
    checkVal("t5_leftY", bulletStartY, 32'd10);

    // Reset during cooldown with the button held
    fireBtn = 1'b0;
    repeat (10) tick();
    tankDir = RIGHT; fireBtn = 1'b1;
    tick();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checkVal("t6_rst_shots", 32'(shotCount), 32'd0);
    checkVal("t6_rst_dir", 32'(bulletStartDir), 32'(RIGHT));
    reset = 1'b0;
    repeat (5) tick();
    checkVal("t6_held", 32'(shotCount), 32'd0);
    fireBtn = 1'b0;
    tick();
    fireBtn = 1'b1;
    tick();
    checkVal("t6_repress", 32'(shotCount), 32'd1);

    // Random traffic
    repeat (3000) begin
      reset   = ($urandom % 150) == 0;
      fireBtn = $urandom % 2;
      bulletExists = ($urandom % 3 == 0) ? 4'hF : 4'($urandom);
      tankDir = 2'($urandom);
      case ($urandom % 3)
        0:       begin tankPosX = $urandom % 40; tankPosY = $urandom % 40; end
        1:       begin tankPosX = 32'hFFFF_FFFF - ($urandom % 40);
                       tankPosY = 32'hFFFF_FFFF - ($urandom % 40); end
        default: begin tankPosX = $urandom; tankPosY = $urandom; end
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
